// File: rtl/key_fifo_writer_pkg.sv
// Shared widths, limits and FSM encoding for the key / key-length FIFO writer.
package key_fifo_writer_pkg;

  localparam int FIFOWIDTH         = 128;
  localparam int IN_WIDTH          = 32;
  localparam int KEYHASH_WIDTH     = 32;
  localparam int MAX_KEY_BYTES_DEF = 64;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PUSH    = 2'd1,
    PUSHLEN = 2'd2,
    DROP    = 2'd3
  } kfwState_e;

endpackage

// File: rtl/key_fifo_writer_packer.sv
// Lane buffer, lane counter and byte counter that pack input words little-endian.
module key_word_packer
  import key_fifo_writer_pkg::*;
#(
  parameter int FIFOWIDTH_P = FIFOWIDTH,
  parameter int IN_WIDTH_P  = IN_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clrBuf,
  input  logic                   clrCnt,
  input  logic                   load,
  input  logic [IN_WIDTH_P-1:0]  iData,
  input  logic                   iLast,
  input  logic [1:0]             iLastBytes,
  output logic [FIFOWIDTH_P-1:0] keyBuf,
  output logic [7:0]             byteCnt,
  output logic                   lastLane
);

  localparam int LANES    = FIFOWIDTH_P / IN_WIDTH_P;
  localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BYTES_IN = IN_WIDTH_P / 8;

  logic [FIFOWIDTH_P-1:0] keyBuf_r;
  logic [LANE_W-1:0]      laneCnt_r;
  logic [7:0]             byteCnt_r;
  logic [IN_WIDTH_P-1:0]  masked_s;
  logic [7:0]             addBytes_s;

  // Zero the unused bytes of a partial final word and size the byte increment
  always_comb begin
    masked_s   = iData;
    addBytes_s = 8'(BYTES_IN);
    if (iLast && (iLastBytes != 2'd0)) begin
      addBytes_s = {6'd0, iLastBytes};
      for (int b = 0; b < BYTES_IN; b++) begin
        if (b >= int'(iLastBytes)) begin
          masked_s[8*b +: 8] = 8'd0;
        end else begin
          masked_s[8*b +: 8] = iData[8*b +: 8];
        end
      end
    end else begin
      addBytes_s = 8'(BYTES_IN);
    end
  end

  // Lane buffer, lane counter and byte counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keyBuf_r  <= '0;
      laneCnt_r <= '0;
      byteCnt_r <= 8'd0;
    end else begin
      if (clrBuf) begin
        keyBuf_r  <= '0;
        laneCnt_r <= '0;
      end else if (load) begin
        for (int l = 0; l < LANES; l++) begin
          if (laneCnt_r == LANE_W'(l)) begin
            keyBuf_r[l*IN_WIDTH_P +: IN_WIDTH_P] <= masked_s;
          end
        end
        laneCnt_r <= laneCnt_r + LANE_W'(1);
      end
      if (clrCnt) begin
        byteCnt_r <= 8'd0;
      end else if (load) begin
        byteCnt_r <= byteCnt_r + addBytes_s;
      end
    end
  end

  assign keyBuf   = keyBuf_r;
  assign byteCnt  = byteCnt_r;
  assign lastLane = (laneCnt_r == LANE_W'(LANES - 1));

endmodule

// File: rtl/key_fifo_writer.sv
// Packs the key byte stream into key-FIFO words, then writes the key length
// (clamped to MAX_KEY_BYTES) into the key-length FIFO.
module key_fifo_writer
  import key_fifo_writer_pkg::*;
#(
  parameter int FIFOWIDTH_P   = FIFOWIDTH,
  parameter int IN_WIDTH_P    = IN_WIDTH,
  parameter int MAX_KEY_BYTES = MAX_KEY_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   oWrKeyClk,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [IN_WIDTH_P-1:0]  iData,
  input  logic                   iLast,
  input  logic [1:0]             iLastBytes,
  input  logic                   iWrKeyFull,
  output logic                   oWrKeyFifo_en,
  output logic [FIFOWIDTH_P-1:0] oKey,
  input  logic                   iWrKeyLenFull,
  output logic                   oWrKeyLenFifo_en,
  output logic [7:0]             oKeyLen,
  output logic                   oOverflow,
  input  logic                   iClrOverflow
);

  kfwState_e              state_r, next_s;
  logic                   ready_r, keyEn_r, lenEn_r, ovf_r, last_r;
  logic [FIFOWIDTH_P-1:0] key_r;
  logic [7:0]             keyLen_r;
  logic                   accept_s, load_s, clrBuf_s, clrCnt_s;
  logic                   keyWr_s, lenWr_s, setOvf_s;
  logic [FIFOWIDTH_P-1:0] keyBuf_s;
  logic [7:0]             byteCnt_s;
  logic                   lastLane_s;

  key_word_packer #(
    .FIFOWIDTH_P (FIFOWIDTH_P),
    .IN_WIDTH_P  (IN_WIDTH_P)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clrBuf     (clrBuf_s),
    .clrCnt     (clrCnt_s),
    .load       (load_s),
    .iData      (iData),
    .iLast      (iLast),
    .iLastBytes (iLastBytes),
    .keyBuf     (keyBuf_s),
    .byteCnt    (byteCnt_s),
    .lastLane   (lastLane_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FILL;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and per-cycle control decode
  always_comb begin
    next_s   = state_r;
    accept_s = iValid && ready_r;
    load_s   = 1'b0;
    clrBuf_s = 1'b0;
    clrCnt_s = 1'b0;
    keyWr_s  = 1'b0;
    lenWr_s  = 1'b0;
    setOvf_s = 1'b0;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          load_s = 1'b1;
          if (iLast || lastLane_s) begin
            next_s = PUSH;
          end else begin
            next_s = FILL;
          end
        end else begin
          next_s = FILL;
        end
      end
      PUSH: begin
        if (!iWrKeyFull) begin
          keyWr_s  = 1'b1;
          clrBuf_s = 1'b1;
          if (last_r) begin
            next_s = PUSHLEN;
          end else if (byteCnt_s >= 8'(MAX_KEY_BYTES)) begin
            next_s   = DROP;
            setOvf_s = 1'b1;
          end else begin
            next_s = FILL;
          end
        end else begin
          next_s = PUSH;
        end
      end
      PUSHLEN: begin
        if (!iWrKeyLenFull) begin
          lenWr_s  = 1'b1;
          clrCnt_s = 1'b1;
          next_s   = FILL;
        end else begin
          next_s = PUSHLEN;
        end
      end
      DROP: begin
        // Byte count is frozen at MAX_KEY_BYTES here, so it doubles as the reported length
        if (accept_s && iLast) begin
          next_s = PUSHLEN;
        end else begin
          next_s = DROP;
        end
      end
      default: begin
        next_s = FILL;
      end
    endcase
  end

  // Registered handshake, FIFO write ports and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r  <= 1'b0;
      keyEn_r  <= 1'b0;
      lenEn_r  <= 1'b0;
      key_r    <= '0;
      keyLen_r <= 8'd0;
      ovf_r    <= 1'b0;
      last_r   <= 1'b0;
    end else begin
      ready_r <= (next_s == FILL) || (next_s == DROP);
      keyEn_r <= keyWr_s;
      lenEn_r <= lenWr_s;
      if (keyWr_s) begin
        key_r <= keyBuf_s;
      end
      if (lenWr_s) begin
        keyLen_r <= byteCnt_s;
      end
      if (load_s) begin
        last_r <= iLast;
      end
      if (setOvf_s) begin
        ovf_r <= 1'b1;
      end else if (iClrOverflow) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign oWrKeyClk        = clk;
  assign oReady           = ready_r;
  assign oWrKeyFifo_en    = keyEn_r;
  assign oKey             = key_r;
  assign oWrKeyLenFifo_en = lenEn_r;
  assign oKeyLen          = keyLen_r;
  assign oOverflow        = ovf_r;

endmodule

// File: tb/tb_key_fifo_writer.sv
// Randomized bench for key_fifo_writer against a byte-level scoreboard model.
module tb_key_fifo_writer;

  localparam int MAXB = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         oWrKeyClk;
  logic         iValid;
  logic         oReady;
  logic [31:0]  iData;
  logic         iLast;
  logic [1:0]   iLastBytes;
  logic         iWrKeyFull;
  logic         oWrKeyFifo_en;
  logic [127:0] oKey;
  logic         iWrKeyLenFull;
  logic         oWrKeyLenFifo_en;
  logic [7:0]   oKeyLen;
  logic         oOverflow;
  logic         iClrOverflow;

  int checks = 0;
  int failures = 0;
  logic [127:0] expKey[$];
  logic [7:0]   expLen[$];
  int wordsSince = 0;
  int lenSeen = 0;
  int keySeen = 0;
  logic [127:0] lastKeySeen = '0;
  logic [7:0]   lastLenSeen = 8'd0;
  bit randFull = 1'b0;
  logic [7:0] keyBytes [0:127];

  key_fifo_writer dut (
    .clk(clk), .rst(rst), .oWrKeyClk(oWrKeyClk), .iValid(iValid), .oReady(oReady),
    .iData(iData), .iLast(iLast), .iLastBytes(iLastBytes), .iWrKeyFull(iWrKeyFull),
    .oWrKeyFifo_en(oWrKeyFifo_en), .oKey(oKey), .iWrKeyLenFull(iWrKeyLenFull),
    .oWrKeyLenFifo_en(oWrKeyLenFifo_en), .oKeyLen(oKeyLen), .oOverflow(oOverflow),
    .iClrOverflow(iClrOverflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop expected key words / lengths as the DUT writes them
  always @(negedge clk) begin
    if (oWrKeyFifo_en) begin
      if (expKey.size() == 0) chk("key_unexpected", 1, 0);
      else chk("key_data", oKey, expKey.pop_front());
      lastKeySeen = oKey;
      wordsSince++;
      keySeen++;
    end
    if (oWrKeyLenFifo_en) begin
      if (expLen.size() == 0) chk("len_unexpected", 1, 0);
      else begin
        logic [7:0] e;
        e = expLen.pop_front();
        chk("key_len", oKeyLen, e);
        chk("len_word_count", wordsSince, (int'(e) + 15) / 16);
      end
      lastLenSeen = oKeyLen;
      wordsSince = 0;
      lenSeen++;
    end
  end

  // Random FIFO backpressure
  always @(negedge clk) begin
    if (randFull) begin
      iWrKeyFull    = ($urandom % 4 == 0);
      iWrKeyLenFull = ($urandom % 4 == 0);
    end
  end

  task automatic driveWord(input logic [31:0] d, input logic last, input logic [1:0] lb);
    int t;
    iValid = 1'b1; iData = d; iLast = last; iLastBytes = lb;
    t = 0;
    while (oReady !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic sendKey(input int n, input bit seq, input bit gaps);
    int m, nw;
    logic [127:0] w;
    nw = (n + 3) / 4;
    for (int i = 0; i < 4 * nw; i++) keyBytes[i] = seq ? i[7:0] : 8'($urandom);
    m = (n > MAXB) ? MAXB : n;
    for (int k = 0; k < (m + 15) / 16; k++) begin
      w = '0;
      for (int b = 0; b < 16; b++)
        if (16 * k + b < m) w[8*b +: 8] = keyBytes[16*k + b];
      expKey.push_back(w);
    end
    expLen.push_back(8'(m));
    for (int k = 0; k < nw; k++) begin
      if (gaps && ($urandom % 4 == 0)) begin
        iValid = 1'b0;
        @(negedge clk);
      end
      driveWord({keyBytes[4*k+3], keyBytes[4*k+2], keyBytes[4*k+1], keyBytes[4*k]},
                k == nw - 1, (k == nw - 1) ? 2'(n % 4) : 2'($urandom));
    end
  endtask

  task automatic waitLen(input int target);
    int t;
    t = 0;
    while (lenSeen < target && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("len_wait", lenSeen, target);
  endtask

  task automatic chkAllZero(input string tag);
    chk(tag, {oReady, oWrKeyFifo_en, oWrKeyLenFifo_en, oOverflow, oKeyLen, oKey}, '0);
  endtask

  initial begin
    int k0, l0, n;
    rst = 1'b0; iValid = 1'b0; iData = '0; iLast = 1'b0; iLastBytes = 2'd0;
    iWrKeyFull = 1'b0; iWrKeyLenFull = 1'b0; iClrOverflow = 1'b0;
    repeat (3) @(negedge clk);
    chkAllZero("reset_outputs");
    rst = 1'b1;
    @(negedge clk);

    // 16-byte ascending key
    sendKey(16, 1'b1, 1'b0);
    iValid = 1'b0;
    waitLen(1);
    chk("k16_word", lastKeySeen, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    chk("k16_len", lastLenSeen, 8'h10);

    // 5-byte key
    sendKey(5, 1'b0, 1'b0);
    iValid = 1'b0;
    waitLen(2);
    chk("k5_upper_zero", lastKeySeen[127:40], '0);
    chk("k5_len", lastLenSeen, 8'h05);

    // Exact max length, then overflow
    sendKey(64, 1'b0, 1'b0);
    iValid = 1'b0;
    waitLen(3);
    chk("k64_no_ovf", oOverflow, 1'b0);
    sendKey(80, 1'b0, 1'b0);
    iValid = 1'b0;
    waitLen(4);
    chk("k80_len", lastLenSeen, 8'h40);
    chk("k80_ovf", oOverflow, 1'b1);
    iClrOverflow = 1'b1;
    @(negedge clk);
    iClrOverflow = 1'b0;
    chk("ovf_cleared", oOverflow, 1'b0);

    // Backpressure on both FIFOs
    iWrKeyFull = 1'b1;
    iWrKeyLenFull = 1'b1;
    sendKey(16, 1'b0, 1'b0);
    iValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_key_en_low", oWrKeyFifo_en, 1'b0);
      chk("bp_ready_low", oReady, 1'b0);
      chk("bp_key_hold", oKey, lastKeySeen);
      @(negedge clk);
    end
    iWrKeyFull = 1'b0;
    @(negedge clk);
    chk("bp_key_en", oWrKeyFifo_en, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_len_en_low", oWrKeyLenFifo_en, 1'b0);
      @(negedge clk);
    end
    iWrKeyLenFull = 1'b0;
    @(negedge clk);
    chk("bp_len_en", oWrKeyLenFifo_en, 1'b1);
    waitLen(5);

    // Back-to-back keys with iValid held high
    k0 = keySeen; l0 = lenSeen;
    sendKey(64, 1'b0, 1'b0);
    sendKey(8, 1'b0, 1'b0);
    sendKey(32, 1'b0, 1'b0);
    sendKey(17, 1'b0, 1'b0);
    iValid = 1'b0;
    waitLen(l0 + 4);
    chk("b2b_words", keySeen - k0, 9);

    // Reset in the middle of a key
    driveWord(32'($urandom), 1'b0, 2'd0);
    driveWord(32'($urandom), 1'b0, 2'd0);
    iValid = 1'b0;
    #2 rst = 1'b0;
    #1 chkAllZero("mid_reset_outputs");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    l0 = lenSeen;
    sendKey(12, 1'b0, 1'b0);
    iValid = 1'b0;
    waitLen(l0 + 1);
    chk("post_reset_len", lastLenSeen, 8'd12);

    // Random keys with random gaps and backpressure
    randFull = 1'b1;
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1, 90);
      l0 = lenSeen;
      sendKey(n, 1'b0, 1'b1);
      iValid = 1'b0;
      waitLen(l0 + 1);
      chk("rand_ovf", oOverflow, n > MAXB);
      if (n > MAXB) begin
        iClrOverflow = 1'b1;
        @(negedge clk);
        iClrOverflow = 1'b0;
      end
    end
    randFull = 1'b0;
    @(negedge clk);
    iWrKeyFull = 1'b0;
    iWrKeyLenFull = 1'b0;
    repeat (4) @(negedge clk);
    chk("key_queue_empty", expKey.size(), 0);
    chk("len_queue_empty", expLen.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
